// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer control core.
package reaction_pkg;

    localparam int MS_W  = 14;
    localparam int DLY_W = 12;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_ARMED   = 3'd2,
        ST_DONE    = 3'd3,
        ST_EARLY   = 3'd4,
        ST_TIMEOUT = 3'd5
    } rt_state_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16/14/13/11), shifting right.
module lfsr16
    import reaction_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_n,
    output logic [15:0] Q
);

    logic [15:0] q_q, q_d;
    logic        fb;

    always_comb begin
        fb  = q_q[0] ^ q_q[2] ^ q_q[3] ^ q_q[5];
        q_d = {fb, q_q[15:1]};
    end

    // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) q_q <= LFSR_SEED;
        else        q_q <= q_d;
    end

    assign Q = q_q;

endmodule

// File: rtl/reaction_timer_fsm.sv
// Reaction timer trial sequencer: random delay, stimulus LED, ms count, early/timeout flags.
// Define BEST_TIME_EN to add the BestMs output tracking the fastest completed trial.
module reaction_timer_fsm
    import reaction_pkg::*;
#(
    parameter int MAX_MS       = 9999,
    parameter int MIN_DELAY_MS = 1000,
    parameter int DELAY_BITS   = 11
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            ClkMS,
    input  logic            Start,
    input  logic            React,
    output logic            LedOn,
    output logic [MS_W-1:0] ReactMs,
    output logic            Valid,
    output logic            Early,
    output logic            Timeout,
`ifdef BEST_TIME_EN
    output logic [MS_W-1:0] BestMs,
`endif
    output logic [2:0]      State
);

    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_WAIT    = ST_WAIT;
    localparam logic [2:0] S_ARMED   = ST_ARMED;
    localparam logic [2:0] S_DONE    = ST_DONE;
    localparam logic [2:0] S_EARLY   = ST_EARLY;
    localparam logic [2:0] S_TIMEOUT = ST_TIMEOUT;

    logic [15:0] lfsr_w;
    logic        unused_lfsr;

    lfsr16 u_lfsr (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Q     (lfsr_w)
    );

    assign unused_lfsr = ^lfsr_w[15:DELAY_BITS];

    // Each input is registered once; the pulse compares it against its previous sample.
    logic clkms_q, clkms_prev_q, start_q, start_prev_q, react_q, react_prev_q;
    logic ms_tick, start_p, react_p;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            clkms_q      <= 1'b0;
            clkms_prev_q <= 1'b0;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            react_q      <= 1'b0;
            react_prev_q <= 1'b0;
        end else begin
            clkms_q      <= ClkMS;
            clkms_prev_q <= clkms_q;
            start_q      <= Start;
            start_prev_q <= start_q;
            react_q      <= React;
            react_prev_q <= react_q;
        end
    end

    assign ms_tick = clkms_q & ~clkms_prev_q;
    assign start_p = start_q & ~start_prev_q;
    assign react_p = react_q & ~react_prev_q;

    logic [2:0]       state_q, state_d;
    logic [DLY_W-1:0] delay_q, delay_d;
    logic [MS_W-1:0]  ms_q, ms_d;
    logic             led_q, led_d, valid_q, valid_d, early_q, early_d, timeout_q, timeout_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        delay_d   = delay_q;
        ms_d      = ms_q;
        led_d     = led_q;
        valid_d   = valid_q;
        early_d   = early_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE, S_DONE, S_EARLY, S_TIMEOUT: begin
                if (start_p) begin
                    state_d   = S_WAIT;
                    delay_d   = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_w[DELAY_BITS-1:0]);
                    ms_d      = '0;
                    led_d     = 1'b0;
                    valid_d   = 1'b0;
                    early_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            S_WAIT: begin
                // A press always wins over a tick, even the one that would arm the LED.
                if (react_p) begin
                    state_d = S_EARLY;
                    early_d = 1'b1;
                end else if (ms_tick) begin
                    if (delay_q == DLY_W'(1)) begin
                        state_d = S_ARMED;
                        led_d   = 1'b1;
                        ms_d    = '0;
                    end else begin
                        delay_d = delay_q - DLY_W'(1);
                    end
                end
            end
            S_ARMED: begin
                if (react_p) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                    led_d   = 1'b0;
                end else if (ms_tick) begin
                    if (ms_q >= MS_W'(MAX_MS - 1)) begin
                        state_d   = S_TIMEOUT;
                        ms_d      = MS_W'(MAX_MS);
                        timeout_d = 1'b1;
                        led_d     = 1'b0;
                    end else begin
                        ms_d = ms_q + MS_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            delay_q   <= '0;
            ms_q      <= '0;
            led_q     <= 1'b0;
            valid_q   <= 1'b0;
            early_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            delay_q   <= delay_d;
            ms_q      <= ms_d;
            led_q     <= led_d;
            valid_q   <= valid_d;
            early_q   <= early_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef BEST_TIME_EN
    logic [MS_W-1:0] best_q, best_d;

    always_comb begin
        best_d = best_q;
        if (state_q == S_ARMED && react_p && ms_q < best_q) best_d = ms_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) best_q <= MS_W'(MAX_MS);
        else        best_q <= best_d;
    end

    assign BestMs = best_q;
`endif

    assign State   = state_q;
    assign LedOn   = led_q;
    assign ReactMs = ms_q;
    assign Valid   = valid_q;
    assign Early   = early_q;
    assign Timeout = timeout_q;

endmodule

// File: tb/tb_reaction_timer_fsm.sv
// Scoreboard bench for reaction_timer_fsm: stimulus pushes trial outcomes, a monitor checks them.
module tb_reaction_timer_fsm;

    localparam int MAX_MS       = 9999;
    localparam int MIN_DELAY_MS = 1000;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic        ClkMS = 1'b0;
    logic        Start = 1'b0;
    logic        React = 1'b0;
    logic        LedOn;
    logic [13:0] ReactMs;
    logic        Valid, Early, Timeout;
    logic [2:0]  State;
`ifdef BEST_TIME_EN
    logic [13:0] BestMs;
`endif

    reaction_timer_fsm #(
        .MAX_MS       (MAX_MS),
        .MIN_DELAY_MS (MIN_DELAY_MS),
        .DELAY_BITS   (11)
    ) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .ClkMS   (ClkMS),
        .Start   (Start),
        .React   (React),
        .LedOn   (LedOn),
        .ReactMs (ReactMs),
        .Valid   (Valid),
        .Early   (Early),
        .Timeout (Timeout),
`ifdef BEST_TIME_EN
        .BestMs  (BestMs),
`endif
        .State   (State)
    );

    always #5 Clk = ~Clk;

    // Outcome kinds: 0 = reacted, 1 = false start, 2 = timeout.
    typedef struct {
        int kind;
        int ms;
        bit led_seen;
        int best;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_best = MAX_MS;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference LFSR: right shift, feedback bit = XOR of bits 0,2,3,5, inserted at bit 15.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] fb;
        fb = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'd1;
        return (v >> 1) | (fb << 15);
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    // Stimulus helpers: every task begins and ends just after a falling clock edge.
    task automatic tick();
        ClkMS = 1'b1;
        @(negedge Clk);
        ClkMS = 1'b0;
        @(negedge Clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic start_trial(output int d);
        repeat ($urandom_range(0, 40)) @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        d = MIN_DELAY_MS + int'(m_lfsr[10:0]);
        @(negedge Clk);
        Start = 1'b0;
        check("start_state", State, 1);
        check("start_ms_clear", ReactMs, 0);
        check("start_flags_clear", {Valid, Early, Timeout, LedOn}, 0);
        @(negedge Clk);
    endtask

    task automatic press(input bit with_tick);
        React = 1'b1;
        ClkMS = with_tick;
        @(negedge Clk);
        ClkMS = 1'b0;
        @(negedge Clk);
        React = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic run_normal(input int r, input bit collide, input bit poke_start);
        int d;
        start_trial(d);
        if (poke_start) begin
            ticks(10);
            Start = 1'b1;
            repeat (3) @(negedge Clk);
            Start = 1'b0;
            @(negedge Clk);
            check("start_ignored_in_wait", State, 1);
            ticks(d - 11);
        end else begin
            ticks(d - 1);
        end
        check("pre_arm_led", LedOn, 0);
        tick();
        check("armed_state", State, 2);
        check("armed_led", LedOn, 1);
        check("armed_ms", ReactMs, 0);
        ticks(r);
        check("count_before_press", ReactMs, r);
        if (r < m_best) m_best = r;
        exp_q.push_back('{kind: 0, ms: r, led_seen: 1'b1, best: m_best});
        press(collide);
    endtask

    task automatic run_early(input int w, input bit final_tick);
        int d;
        start_trial(d);
        if (final_tick) w = d - 1;
        ticks(w);
        exp_q.push_back('{kind: 1, ms: 0, led_seen: 1'b0, best: m_best});
        press(final_tick);
    endtask

    task automatic run_timeout();
        int d;
        start_trial(d);
        ticks(d);
        exp_q.push_back('{kind: 2, ms: MAX_MS, led_seen: 1'b1, best: m_best});
        ticks(MAX_MS);
        ticks(3);
        check("timeout_saturates", ReactMs, MAX_MS);
        check("timeout_holds_state", State, 5);
    endtask

    // Monitor: a rising result flag means the DUT presents a finished trial.
    initial begin
        exp_t e;
        bit   term_prev = 1'b0;
        bit   led_seen  = 1'b0;
        bit   term;
        forever begin
            @(negedge Clk);
            if (!Rst_n) begin
                term_prev = 1'b0;
                led_seen  = 1'b0;
            end else begin
                if (LedOn === 1'b1) led_seen = 1'b1;
                term = (Valid | Early | Timeout) === 1'b1;
                if (term && !term_prev) begin
                    check("result_expected", (exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("res_state", State, (e.kind == 0) ? 3 : (e.kind == 1) ? 4 : 5);
                        check("res_ms", ReactMs, e.ms);
                        check("res_valid", Valid, e.kind == 0);
                        check("res_early", Early, e.kind == 1);
                        check("res_timeout", Timeout, e.kind == 2);
                        check("res_led_off", LedOn, 0);
                        check("res_led_seen", led_seen, e.led_seen);
`ifdef BEST_TIME_EN
                        check("res_best", BestMs, e.best);
`endif
                    end
                    led_seen = 1'b0;
                end
                term_prev = term;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        #2 Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_state", State, 0);
        check("rst_outputs", {LedOn, Valid, Early, Timeout}, 0);
        check("rst_ms", ReactMs, 0);
`ifdef BEST_TIME_EN
        check("rst_best", BestMs, MAX_MS);
`endif
        Rst_n = 1'b1;
        @(negedge Clk);

        run_normal(300, 1'b0, 1'b0);
        run_normal(200, 1'b0, 1'b0);
        run_early(500, 1'b0);
        run_normal(400, 1'b0, 1'b0);
        run_normal(250, 1'b0, 1'b1);
        run_normal(100, 1'b1, 1'b0);
        run_early(0, 1'b1);
        run_timeout();

        // Reset while armed at count 42 must clear everything without waiting for a clock edge.
        start_trial(d);
        ticks(d + 42);
        check("pre_reset_ms", ReactMs, 42);
        #2 Rst_n = 1'b0;
        #1;
        check("async_rst_state", State, 0);
        check("async_rst_outputs", {LedOn, Valid, Early, Timeout}, 0);
        check("async_rst_ms", ReactMs, 0);
        check("async_rst_lfsr", dut.u_lfsr.Q, 16'hACE1);
        m_best = MAX_MS;
`ifdef BEST_TIME_EN
        check("async_rst_best", BestMs, m_best);
`endif
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (4) @(negedge Clk);
        check("no_pending_results", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reaction_timer_fsm.md
# reaction_timer_fsm

Control core of the reaction timer. It consumes the 1 ms `ClkMS` signal from the clock divider and runs the trial sequence. On `Start`, it waits a pseudo-random delay, then lights the stimulus LED and counts elapsed milliseconds until `React` is pressed. It flags false starts and timeouts, and presents the result to the display stage downstream.

## Interface
Parameters:
- `MAX_MS`, 9999: count ceiling in ms; reaching it ends the trial as a timeout.
- `MIN_DELAY_MS`, 1000: fixed part of the random pre-stimulus delay.
- `DELAY_BITS`, 11: number of LFSR bits added to the delay, giving 0..2047 ms extra.

Ports (one clock; reset is asynchronous and active-low):
- `Clk`  in  1  system clock, 100 MHz.
- `Rst_n`  in  1  asynchronous active-low reset.
- `ClkMS`  in  1  1 ms divided clock from the divider, synchronous to `Clk`.
- `Start`  in  1  debounced, synchronised start button, level.
- `React`  in  1  debounced, synchronised reaction button, level.
- `LedOn`  out  1  stimulus LED.
- `ReactMs`  out  14  elapsed ms, binary.
- `Valid`  out  1  `ReactMs` holds a completed result.
- `Early`  out  1  false-start flag.
- `Timeout`  out  1  `MAX_MS` reached with no reaction.
- `State`  out  3  current state encoding, for debug.

## Operation
- **Edge detection:** `ClkMS`, `Start` and `React` are each registered once. Each rising edge produces a one-`Clk` pulse: `MsTick`, `StartP`, `ReactP`.
- **LFSR:** free-running 16-bit Fibonacci LFSR, taps 16/14/13/11, seed 16'hACE1. It advances every `Clk` in every state and never reaches zero.
- **States** (encoding): IDLE=0, WAIT=1, ARMED=2, DONE=3, EARLY=4, TIMEOUT=5.
- **IDLE:**
  - `StartP` → WAIT.
  - Load `DelayCnt = MIN_DELAY_MS + lfsr[DELAY_BITS-1:0]`.
  - Clear `ReactMs` and all flags.
- **WAIT:**
  - `MsTick` decrements `DelayCnt`.
  - `ReactP` → EARLY.
  - `MsTick` when `DelayCnt == 1` → ARMED, with `LedOn = 1` and `ReactMs = 0`.
- **ARMED:**
  - `MsTick` increments `ReactMs`.
  - `ReactP` → DONE: freeze `ReactMs`, set `Valid`, clear `LedOn`.
  - `MsTick` with `ReactMs == MAX_MS-1` → TIMEOUT, with `ReactMs = MAX_MS`, `LedOn = 0`.
- **DONE / EARLY / TIMEOUT:** hold all outputs. `StartP` starts a new trial exactly as from IDLE: reload delay, clear flags and `ReactMs`.
- **Simultaneous events:**
  - `ReactP` beats `MsTick` in the same cycle. In WAIT that means EARLY, even on the final tick. In ARMED the count is not incremented.
  - `StartP` is ignored in WAIT and ARMED.
  - `StartP` beats `ReactP` in IDLE and in the terminal states.
- **Arithmetic:** `DelayCnt` is 12 bits wide, with a maximum of 3047. `ReactMs` saturates at `MAX_MS` and never wraps.
- **Reset:** `Rst_n` low at any time, including mid-trial, immediately forces:
  - state IDLE;
  - `LedOn`, `ReactMs`, `Valid`, `Early`, `Timeout` all 0;
  - edge registers 0;
  - LFSR = 16'hACE1.

## Timing
- All outputs are registered.
- `StartP` is valid 1 `Clk` after the `Start` rise. The state changes on the following edge, giving 2 `Clk` from `Start` rise to `State` = WAIT.
- `ReactMs` increments and `LedOn` rises 2 `Clk` after the `ClkMS` rising edge.
- `ReactMs` freezes and `Valid` rises 2 `Clk` after the `React` rise.
- Holding a button high produces no further events; only rising edges count.

## Configuration
- `BEST_TIME_EN` defined:
  - Adds output `BestMs[13:0]`, reset value `MAX_MS`.
  - On entry to DONE, `BestMs` is updated if the frozen `ReactMs` is less than `BestMs`.
  - EARLY and TIMEOUT never update it. It is cleared only by `Rst_n`.
- Without `BEST_TIME_EN`: the port and its register are absent, and all other behaviour is identical.

## Structure
- **Package `reaction_pkg`:**
  - state enum `rt_state_t` with the encodings above;
  - `MS_W = 14`, `DLY_W = 12`;
  - `LFSR_SEED = 16'hACE1`.
- **Sub-module `lfsr16`:** ports `Clk`, `Rst_n`, `Q[15:0]`. It is the only natural split. Edge detection and the FSM stay in the top module.

## Test plan
- **Normal trial:** reset, pulse `Start`, force the LFSR low bits to 0 (or read them), and give `React` 250 ms after the LED → `ReactMs` = 250, `Valid` = 1, `State` = 3, `LedOn` = 0.
- **False start:** `React` 500 ms after `Start` → `Early` = 1, `State` = 4, `LedOn` never 1, `ReactMs` = 0.
- **Timeout:** no `React` after the LED → `ReactMs` = 9999, `Timeout` = 1, `State` = 5.
- **Simultaneous events:** `React` rising in the same cycle as `MsTick` in ARMED at count 100 → `ReactMs` = 100, not 101. The same collision on the final WAIT tick → EARLY.
- **Mid-trial reset:** `Rst_n` low while ARMED at count 42 → all outputs 0 and `State` = 0 asynchronously, LFSR = 16'hACE1.
- **Best time (`BEST_TIME_EN`):** trials of 300 ms, 200 ms, an early press, then 400 ms → `BestMs` reads 9999, 300, 200, 200, 200.
